// File: rtl/loop_pkg.sv
// Shared types, default sizes and sizing helpers for the hardware loop stack.
package loop_pkg;

  localparam int LOOP_WIDTH = 16;
  localparam int LOOP_PC_W  = 16;
  localparam int LOOP_DEPTH = 4;

  // One nested-loop record at the default sizes.
  typedef struct packed {
    logic [LOOP_WIDTH-1:0] cnt;
    logic [LOOP_PC_W-1:0]  pc;
  } entry_t;

  // Width needed to count 0..DEPTH live entries.
  function automatic int depth_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_w(input int width, input int pc_w);
    return width + pc_w;
  endfunction

endpackage

// File: rtl/loop_iter_stack_if.sv
// Instruction-side bundle of the loop stack: loop-start/loop-end strobes in, branch and status out.
interface loop_iter_stack_if
  import loop_pkg::*;
#(
  parameter int WIDTH = LOOP_WIDTH,
  parameter int PC_W  = LOOP_PC_W,
  parameter int DEPTH = LOOP_DEPTH
);

  localparam int DW = depth_w(DEPTH);

  logic             push;
  logic [WIDTH-1:0] push_cnt;
  logic [PC_W-1:0]  push_pc;
  logic             iter;
  logic             flush;

  logic             loop_back;
  logic [PC_W-1:0]  loop_pc;
  logic             last_iter;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             ovf_err;
  logic             udf_err;
  logic             zero_skip;

  modport master (
    output push, push_cnt, push_pc, iter, flush,
    input  loop_back, loop_pc, last_iter, depth, empty, full,
           ovf_err, udf_err, zero_skip
  );

  modport slave (
    input  push, push_cnt, push_pc, iter, flush,
    output loop_back, loop_pc, last_iter, depth, empty, full,
           ovf_err, udf_err, zero_skip
  );

endinterface

// File: rtl/loop_stack_mem.sv
// DEPTH-entry register stack with a top pointer; supports push, pop, replace-top and top rewrite.
module loop_stack_mem
  import loop_pkg::*;
#(
  parameter int WIDTH = LOOP_WIDTH,
  parameter int PC_W  = LOOP_PC_W,
  parameter int DEPTH = LOOP_DEPTH,
  localparam int DW   = depth_w(DEPTH),
  localparam int EW   = entry_w(WIDTH, PC_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [EW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          top_we_i,
  input  logic [EW-1:0] top_wdata_i,
  output logic [EW-1:0] top_o,
  output logic [DW-1:0] depth_o
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [DW-1:0] ptr_q;
  logic [DW-1:0] ptrMinus1;
  logic [AW-1:0] topIdx;
  logic [AW-1:0] pushIdx;
  logic          isEmpty;
  logic          isFull;

  assign ptrMinus1 = ptr_q - DW'(1);
  assign topIdx    = ptrMinus1[AW-1:0];
  assign pushIdx   = ptr_q[AW-1:0];
  assign isEmpty   = (ptr_q == '0);
  assign isFull    = (ptr_q == DW'(DEPTH));

  // Push together with pop rewrites the vacated top slot, so depth is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
    end else begin
      if (top_we_i && !isEmpty) mem_q[topIdx] <= top_wdata_i;
      unique case ({push_i, pop_i})
        2'b10: begin
          if (!isFull) begin
            mem_q[pushIdx] <= push_data_i;
            ptr_q          <= ptr_q + DW'(1);
          end
        end
        2'b01: begin
          if (!isEmpty) ptr_q <= ptrMinus1;
        end
        2'b11: begin
          if (!isEmpty) mem_q[topIdx] <= push_data_i;
        end
        default: ;
      endcase
    end
  end

  assign top_o   = isEmpty ? '0 : mem_q[topIdx];
  assign depth_o = ptr_q;

endmodule

// File: rtl/loop_iter_stack.sv
// Nested counted-loop controller: decides branch-back vs. fall-through at each loop end.
module loop_iter_stack
  import loop_pkg::*;
#(
  parameter int WIDTH = LOOP_WIDTH,
  parameter int PC_W  = LOOP_PC_W,
  parameter int DEPTH = LOOP_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  loop_iter_stack_if.slave  bus_io
);

  localparam int DW = depth_w(DEPTH);
  localparam int EW = entry_w(WIDTH, PC_W);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic [PC_W-1:0]  pc;
  } stk_entry_t;

  stk_entry_t    topEntry;
  stk_entry_t    pushEntry;
  stk_entry_t    decEntry;
  logic [EW-1:0] topData;
  logic [DW-1:0] stkDepth;

  logic isEmpty, isFull;
  logic iterLive, iterPop, iterDec;
  logic pushLive, pushOk, pushOvf, pushZero, iterUdf;

  logic            loopBack_q, loopBack_d;
  logic [PC_W-1:0] loopPc_q, loopPc_d;
  logic            ovfErr_q, ovfErr_d;
  logic            udfErr_q, udfErr_d;
  logic            zeroSkip_q, zeroSkip_d;

  assign topEntry = topData;
  assign isEmpty  = (stkDepth == '0);
  assign isFull   = (stkDepth == DW'(DEPTH));

  // Iter acts on the existing top before the push; a popping iter frees a slot for the push.
  always_comb begin
    iterLive  = bus_io.iter && !isEmpty && !bus_io.flush;
    iterPop   = iterLive && (topEntry.cnt == WIDTH'(1));
    iterDec   = iterLive && (topEntry.cnt > WIDTH'(1));
    iterUdf   = bus_io.iter && isEmpty && !bus_io.flush;
    pushZero  = bus_io.push && (bus_io.push_cnt == '0) && !bus_io.flush;
    pushLive  = bus_io.push && (bus_io.push_cnt != '0) && !bus_io.flush;
    pushOk    = pushLive && (!isFull || iterPop);
    pushOvf   = pushLive && isFull && !iterPop;
    pushEntry = '{cnt: bus_io.push_cnt, pc: bus_io.push_pc};
    decEntry  = '{cnt: topEntry.cnt - WIDTH'(1), pc: topEntry.pc};
  end

  always_comb begin
    loopBack_d = iterDec;
    loopPc_d   = iterDec ? topEntry.pc : loopPc_q;
    ovfErr_d   = ovfErr_q | pushOvf;
    udfErr_d   = udfErr_q | iterUdf;
    zeroSkip_d = pushZero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loopBack_q <= 1'b0;
      loopPc_q   <= '0;
      ovfErr_q   <= 1'b0;
      udfErr_q   <= 1'b0;
      zeroSkip_q <= 1'b0;
    end else begin
      loopBack_q <= loopBack_d;
      loopPc_q   <= loopPc_d;
      ovfErr_q   <= ovfErr_d;
      udfErr_q   <= udfErr_d;
      zeroSkip_q <= zeroSkip_d;
    end
  end

  loop_stack_mem #(
    .WIDTH (WIDTH),
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (bus_io.flush),
    .push_i      (pushOk),
    .push_data_i (pushEntry),
    .pop_i       (iterPop),
    .top_we_i    (iterDec),
    .top_wdata_i (decEntry),
    .top_o       (topData),
    .depth_o     (stkDepth)
  );

  assign bus_io.loop_back = loopBack_q;
  assign bus_io.loop_pc   = loopPc_q;
  assign bus_io.last_iter = !isEmpty && (topEntry.cnt == WIDTH'(1));
  assign bus_io.depth     = stkDepth;
  assign bus_io.empty     = isEmpty;
  assign bus_io.full      = isFull;
  assign bus_io.ovf_err   = ovfErr_q;
  assign bus_io.udf_err   = udfErr_q;
  assign bus_io.zero_skip = zeroSkip_q;

endmodule

// File: tb/tb_loop_iter_stack.sv
// Directed bench for loop_iter_stack: queue-based loop model checked every cycle plus literal pins.
module tb_loop_iter_stack;

  localparam int WIDTH = 16;
  localparam int PC_W  = 16;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   checkEn;

  typedef struct {
    int cnt;
    int pc;
  } ment_t;

  ment_t mq[$];
  bit    mLoopBack;
  int    mLoopPc;
  bit    mOvf;
  bit    mUdf;
  bit    mZero;

  loop_iter_stack_if #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  loop_iter_stack #(.WIDTH(WIDTH), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mLoopBack = 0;
    mLoopPc   = 0;
    mOvf      = 0;
    mUdf      = 0;
    mZero     = 0;
  endtask

  // Loop-end acts on the current innermost loop, then the loop-start is considered.
  task automatic modelStep(input bit p, input int c, input int pc, input bit it, input bit fl);
    ment_t e;
    mZero     = 0;
    mLoopBack = 0;
    if (fl) begin
      mq.delete();
    end else begin
      if (it) begin
        if (mq.size() == 0) mUdf = 1;
        else if (mq[$].cnt > 1) begin
          e = mq.pop_back();
          e.cnt = e.cnt - 1;
          mq.push_back(e);
          mLoopBack = 1;
          mLoopPc   = e.pc;
        end else begin
          void'(mq.pop_back());
        end
      end
      if (p) begin
        if (c == 0) mZero = 1;
        else if (mq.size() < DEPTH) begin
          e.cnt = c;
          e.pc  = pc;
          mq.push_back(e);
        end else mOvf = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("loop_back", 32'(bus.loop_back), 32'(mLoopBack));
      checkOutput("loop_pc",   32'(bus.loop_pc),   32'(mLoopPc));
      checkOutput("last_iter", 32'(bus.last_iter),
                  32'(mq.size() > 0 && mq[$].cnt == 1));
      checkOutput("depth",     32'(bus.depth),     32'(mq.size()));
      checkOutput("empty",     32'(bus.empty),     32'(mq.size() == 0));
      checkOutput("full",      32'(bus.full),      32'(mq.size() == DEPTH));
      checkOutput("ovf_err",   32'(bus.ovf_err),   32'(mOvf));
      checkOutput("udf_err",   32'(bus.udf_err),   32'(mUdf));
      checkOutput("zero_skip", 32'(bus.zero_skip), 32'(mZero));
    end
  end

  task automatic applyStimulus(input bit p, input int c, input int pc, input bit it, input bit fl);
    bus.push     = p;
    bus.push_cnt = WIDTH'(c);
    bus.push_pc  = PC_W'(pc);
    bus.iter     = it;
    bus.flush    = fl;
    @(posedge clk);
    modelStep(p, c, pc, it, fl);
    #1;
    bus.push     = 1'b0;
    bus.push_cnt = '0;
    bus.push_pc  = '0;
    bus.iter     = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".depth"},     32'(bus.depth),     32'd0);
    checkOutput({tag, ".empty"},     32'(bus.empty),     32'd1);
    checkOutput({tag, ".full"},      32'(bus.full),      32'd0);
    checkOutput({tag, ".loop_back"}, 32'(bus.loop_back), 32'd0);
    checkOutput({tag, ".loop_pc"},   32'(bus.loop_pc),   32'd0);
    checkOutput({tag, ".last_iter"}, 32'(bus.last_iter), 32'd0);
    checkOutput({tag, ".ovf_err"},   32'(bus.ovf_err),   32'd0);
    checkOutput({tag, ".udf_err"},   32'(bus.udf_err),   32'd0);
    checkOutput({tag, ".zero_skip"}, 32'(bus.zero_skip), 32'd0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    checkEn = 0;
    rst_n   = 1'b0;
    bus.push = 1'b0; bus.push_cnt = '0; bus.push_pc = '0;
    bus.iter = 1'b0; bus.flush = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n   = 1'b1;
    checkEn = 1;

    // Single loop of three iterations.
    applyStimulus(1, 3, 'h40, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1.it1.loop_back", 32'(bus.loop_back), 32'd1);
    checkOutput("t1.it1.loop_pc",   32'(bus.loop_pc),   32'h40);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1.it2.loop_back", 32'(bus.loop_back), 32'd1);
    checkOutput("t1.it2.last_iter", 32'(bus.last_iter), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t1.it3.loop_back", 32'(bus.loop_back), 32'd0);
    checkOutput("t1.it3.empty",     32'(bus.empty),     32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t1.idle.loop_pc",  32'(bus.loop_pc),   32'h40);

    // Two nested loops of two iterations each.
    applyStimulus(1, 2, 'h10, 0, 0);
    applyStimulus(1, 2, 'h20, 0, 0);
    checkOutput("t2.push.depth", 32'(bus.depth), 32'd2);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2.it1.depth",   32'(bus.depth),   32'd2);
    checkOutput("t2.it1.loop_pc", 32'(bus.loop_pc), 32'h20);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2.it2.depth",     32'(bus.depth),     32'd1);
    checkOutput("t2.it2.loop_back", 32'(bus.loop_back), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2.it3.loop_back", 32'(bus.loop_back), 32'd1);
    checkOutput("t2.it3.loop_pc",   32'(bus.loop_pc),   32'h10);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t2.it4.depth", 32'(bus.depth), 32'd0);

    // Overfill, zero-count push, decrement alongside a dropped push.
    for (int i = 0; i < 5; i++) applyStimulus(1, 5, 'h100 + i, 0, 0);
    checkOutput("t3.full",    32'(bus.full),    32'd1);
    checkOutput("t3.ovf_err", 32'(bus.ovf_err), 32'd1);
    checkOutput("t3.depth",   32'(bus.depth),   32'd4);
    applyStimulus(1, 0, 'h999, 0, 0);
    checkOutput("t3.zero_skip.on", 32'(bus.zero_skip), 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3.zero_skip.off", 32'(bus.zero_skip), 32'd0);
    checkOutput("t3.zero.depth",    32'(bus.depth),     32'd4);
    applyStimulus(1, 9, 'h555, 1, 0);
    checkOutput("t3.decpush.loop_pc", 32'(bus.loop_pc), 32'h103);

    // Asynchronous reset between clock edges.
    checkEn = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async");
    modelReset();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    checkEn = 1;

    // Pop-and-push while full is a legal replacement.
    applyStimulus(1, 5, 'h201, 0, 0);
    applyStimulus(1, 5, 'h202, 0, 0);
    applyStimulus(1, 5, 'h203, 0, 0);
    applyStimulus(1, 1, 'h300, 0, 0);
    checkOutput("t4.last_iter", 32'(bus.last_iter), 32'd1);
    applyStimulus(1, 7, 'h400, 1, 0);
    checkOutput("t4.repl.depth",   32'(bus.depth),   32'd4);
    checkOutput("t4.repl.ovf_err", 32'(bus.ovf_err), 32'd0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t4.it.loop_pc", 32'(bus.loop_pc), 32'h400);

    // Decrement-then-push, then flush beating a concurrent iter.
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 3, 'h500, 0, 0);
    applyStimulus(1, 4, 'h600, 1, 0);
    checkOutput("t5.decpush.depth", 32'(bus.depth), 32'd2);
    applyStimulus(1, 2, 'h700, 0, 0);
    checkOutput("t5.pre.depth", 32'(bus.depth), 32'd3);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t5.flush.depth",     32'(bus.depth),     32'd0);
    checkOutput("t5.flush.loop_back", 32'(bus.loop_back), 32'd0);
    checkOutput("t5.flush.udf_err",   32'(bus.udf_err),   32'd0);

    // Underflow is sticky; a push alongside it still lands.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("t6.udf_err", 32'(bus.udf_err), 32'd1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t6.udf_sticky", 32'(bus.udf_err), 32'd1);
    applyStimulus(1, 2, 'h800, 1, 0);
    checkOutput("t6.pushudf.depth", 32'(bus.depth), 32'd1);
    applyStimulus(0, 0, 0, 0, 0);

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/loop_iter_stack.md
Name: loop_iter_stack

Overview:
- Hardware loop controller for the processor core's counted-loop (repeat/return) instructions.
- Generalises the single-level iteration counter into a DEPTH-entry stack of nested loops.
- Each entry holds a WIDTH-bit remaining-iteration count and the loop-start PC.
- At each loop-end instruction it either branches back (count > 1) or retires the entry and falls through; it flags last iteration, overflow and underflow.

Parameters:
- WIDTH, 16, iteration-count width in bits
- PC_W, 16, program-counter width in bits
- DEPTH, 4, maximum loop nesting levels (power of 2, >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- push  input  1  loop-start instruction: open new loop
- push_cnt  input  WIDTH  iteration count for new loop
- push_pc  input  PC_W  loop-body start PC for new loop
- iter  input  1  loop-end instruction reached
- flush  input  1  synchronous clear of all entries (pipeline flush/exception)
- loop_back  output  1  registered: branch back to loop_pc this cycle
- loop_pc  output  PC_W  registered: target PC, valid with loop_back
- last_iter  output  1  top entry count == 1 (next iter retires it)
- depth  output  $clog2(DEPTH)+1  live entry count
- empty  output  1  depth == 0
- full  output  1  depth == DEPTH
- ovf_err  output  1  sticky: push while full (non-retiring)
- udf_err  output  1  sticky: iter while empty
- zero_skip  output  1  one-cycle pulse: push with push_cnt == 0 was dropped

Behaviour:
- Reset (async, rst_n low): depth=0, all entries 0, loop_back=0, loop_pc=0, last_iter=0, ovf_err=0, udf_err=0, zero_skip=0. empty=1, full=0.
- Push:
  - push_cnt >= 1 and not full: write {push_cnt, push_pc} above top; depth++.
  - push_cnt == 0: drop the push and pulse zero_skip; depth unchanged.
  - Full: drop the push and set ovf_err.
- Iter:
  - Empty: set udf_err; no other effect.
  - Top count > 1: decrement top count; next cycle loop_back=1, loop_pc=top pc.
  - Top count == 1: pop (depth--); next cycle loop_back=0.
- Latency: loop_back and loop_pc are registered, valid exactly 1 cycle after iter. Both are 0 and hold-last respectively when no iter.
- last_iter is combinational from stack state: !empty && top count == 1.
- Push and iter in the same cycle:
  - iter acts on the existing top first, then the push is applied.
  - If iter pops, the new entry takes the vacated slot; depth is unchanged. Legal even when full, so ovf_err is not set.
  - If iter decrements, the push lands above it; ovf_err applies if already full.
  - push with iter while empty: udf_err set; the push still succeeds.
- flush: depth=0 and loop_back=0 next cycle. Flush has priority over push and iter in the same cycle. Sticky errors are unaffected; only rst_n clears them.
- Counts are unsigned. Decrement never wraps, because count 1 pops instead of going to 0.
- Entries above depth are don't-care but must not affect outputs.
- All state is on clk, async reset only. No latches and no # delays.

Decomposition:
- Shared package loop_pkg:
  - entry struct {cnt[WIDTH], pc[PC_W]}
  - depth-width function
  - default WIDTH/PC_W/DEPTH constants
- One sub-module is natural: loop_stack_mem, a DEPTH-entry register array with top pointer providing push/pop/replace-top/write-top.
- Control (decrement, pop decision, errors, output regs) lives in loop_iter_stack.

Test Plan:
- Reset then push(cnt=3, pc=0x0040) and 3 iters:
  - loop_back=1, loop_pc=0x0040 after iters 1 and 2; loop_back=0 after iter 3.
  - last_iter=1 after iter 2; empty=1 at end.
- Nesting: push(2, 0x10), push(2, 0x20), 4 iters:
  - loop_back pattern 1(0x20), 0, 1(0x10), 0.
  - depth sequence 2, 2, 1, 1, 0.
- Boundaries, DEPTH=4:
  - 5 pushes of cnt=5: full=1, ovf_err=1, depth=4.
  - iter on empty stack: udf_err=1 and stays 1 until rst_n.
  - push(cnt=0): zero_skip pulses for 1 cycle; depth unchanged.
- Simultaneous push and iter:
  - Top count=1, full: depth stays 4, new entry on top, no ovf_err.
  - Top count=3: decrement to 2, then push, depth+1.
- flush and async reset mid-loop:
  - flush with depth=3 plus concurrent iter: depth=0, loop_back=0, no udf_err.
  - rst_n pulsed low mid-cycle: all outputs 0 immediately, without waiting for a clk edge.
